// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: phase sequencer for the intersection light controller.
// Counts clk1 seconds per phase, drives the green-end (_45s) and yellow-end (_15s)
// strobes that the light FSM samples, truncates green on an opposing pedestrian
// request, supports a maintenance hold and exposes the seconds left in the phase.
//
// Handshake: there is no valid/ready pair here; _45s/_15s are single-cycle
// level strobes decoded from registers (and hold), and both this block and the
// light FSM act on them at the same clk1 edge. ped_ack is a one-cycle pulse.
module traffic_phase_timer #(
    parameter int GREEN_S     = 45,
    parameter int YELLOW_S    = 15,
    parameter int MIN_GREEN_S = 10,
    parameter int CNT_W       = 6
) (
    input  logic             clk1,
    input  logic             clr,
    input  logic             ped_ns,
    input  logic             ped_ew,
    input  logic             hold,
    output logic             _45s,
    output logic             _15s,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remain,
    output logic [1:0]       ped_ack
);

    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    // Counter reload values and the count at or below which a pending
    // opposing request may end green (elapsed >= MIN_GREEN_S-1).
    localparam logic [CNT_W-1:0] GRN_LD   = CNT_W'(GREEN_S - 1);
    localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] TRUNC_AT = CNT_W'(GREEN_S - MIN_GREEN_S);

    phase_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pend_ns, pend_ns_nx;
    logic             pend_ew, pend_ew_nx;
    logic [1:0]       ack_nx;
    logic             term_g, term_y, pend_opp;
    logic             adv, enter_ns, enter_ew;

    // State register: phase, countdown, pending requests and ack pulse.
    always_ff @(posedge clk1 or posedge clr) begin
        if (clr) begin
            state   <= NS_GREEN;
            cnt     <= GRN_LD;
            pend_ns <= 1'b0;
            pend_ew <= 1'b0;
            ped_ack <= 2'b00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend_ns <= pend_ns_nx;
            pend_ew <= pend_ew_nx;
            ped_ack <= ack_nx;
        end
    end

    // Next-state: advance on a strobe, count down otherwise unless held,
    // latch requests for the direction not in (or leaving) green.
    always_comb begin
        adv        = term_g | term_y;
        state_nx   = state;
        cnt_nx     = cnt;
        enter_ns   = 1'b0;
        enter_ew   = 1'b0;
        pend_ns_nx = pend_ns;
        pend_ew_nx = pend_ew;
        ack_nx     = 2'b00;
        if (adv) begin
            state_nx = phase_t'(state + 2'd1);
            cnt_nx   = state_nx[0] ? YEL_LD : GRN_LD;
            enter_ns = (state == EW_YELLOW);
            enter_ew = (state == NS_YELLOW);
        end else if (!hold) begin
            cnt_nx = cnt - CNT_W'(1);
        end
        // A request arriving on the edge that starts its own green is already served.
        if (enter_ns) begin
            pend_ns_nx = 1'b0;
            ack_nx[0]  = pend_ns;
        end else if (ped_ns && state_nx != NS_GREEN) begin
            pend_ns_nx = 1'b1;
        end
        if (enter_ew) begin
            pend_ew_nx = 1'b0;
            ack_nx[1]  = pend_ew;
        end else if (ped_ew && state_nx != EW_GREEN) begin
            pend_ew_nx = 1'b1;
        end
    end

    // Outputs: strobes decoded from registers and hold only, plus display.
    always_comb begin
        pend_opp = (state == NS_GREEN) ? pend_ew : pend_ns;
        term_g   = !state[0] && !hold &&
                   ((cnt == '0) || (pend_opp && (cnt <= TRUNC_AT)));
        term_y   = state[0] && !hold && (cnt == '0);
        _45s     = term_g;
        _15s     = term_y;
        phase    = state;
        remain   = cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer: directed scenarios followed by random
// pedestrian/hold traffic, all checked against an elapsed-time phase model.
module tb_traffic_phase_timer;

    localparam int GREEN_S     = 45;
    localparam int YELLOW_S    = 15;
    localparam int MIN_GREEN_S = 10;
    localparam int CNT_W       = 6;

    logic             clk1 = 1'b0;
    logic             clr;
    logic             ped_ns, ped_ew, hold;
    logic             s45, s15;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remain;
    logic [1:0]       ped_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s45_q[$];
    int s15_q[$];
    int t0;

    // Reference model: phase index, seconds elapsed in phase, pending flags.
    int       m_phase;
    int       m_e;
    bit       m_pns, m_pew;
    bit [1:0] m_ack;

    traffic_phase_timer #(
        .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S),
        .MIN_GREEN_S(MIN_GREEN_S), .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1), .clr(clr), .ped_ns(ped_ns), .ped_ew(ped_ew), .hold(hold),
        ._45s(s45), ._15s(s15), .phase(phase), .remain(remain), .ped_ack(ped_ack)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_e     = 0;
        m_pns   = 0;
        m_pew   = 0;
        m_ack   = 2'b00;
    endtask

    // One clk1 cycle: drive inputs after the falling edge, check, then advance.
    task automatic step(input bit pn, input bit pe, input bit h);
        bit even, popp, tg, ty, adv, ns_now, ns_nx, ew_now, ew_nx;
        int len, nxt;
        ped_ns = pn;
        ped_ew = pe;
        hold   = h;
        #1;
        even = (m_phase % 2 == 0);
        popp = (m_phase == 0) ? m_pew : m_pns;
        len  = even ? GREEN_S : YELLOW_S;
        tg   = even && !h && (m_e == GREEN_S - 1 || (popp && m_e >= MIN_GREEN_S - 1));
        ty   = !even && !h && (m_e == YELLOW_S - 1);
        chk("phase", 32'(phase), 32'(m_phase));
        chk("remain", 32'(remain), 32'(len - m_e));
        chk("s45", 32'(s45), 32'(tg));
        chk("s15", 32'(s15), 32'(ty));
        chk("ped_ack", 32'(ped_ack), 32'(m_ack));
        if (s45) s45_q.push_back(cyc);
        if (s15) s15_q.push_back(cyc);
        adv    = tg || ty;
        nxt    = adv ? (m_phase + 1) % 4 : m_phase;
        ns_now = (m_phase == 0);
        ns_nx  = (nxt == 0);
        ew_now = (m_phase == 2);
        ew_nx  = (nxt == 2);
        m_ack  = 2'b00;
        if (!ns_now && ns_nx) begin
            m_ack[0] = m_pns;
            m_pns    = 0;
        end else if (pn && !ns_nx) begin
            m_pns = 1;
        end
        if (!ew_now && ew_nx) begin
            m_ack[1] = m_pew;
            m_pew    = 0;
        end else if (pe && !ew_nx) begin
            m_pew = 1;
        end
        m_e     = adv ? 0 : (h ? m_e : m_e + 1);
        m_phase = nxt;
        @(posedge clk1);
        @(negedge clk1);
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic go_phase(input int p);
        int n;
        n = 0;
        while (!(m_phase == p && m_e == 0) && n < 300) begin
            step(0, 0, 0);
            n++;
        end
        chk("go_phase_bound", 32'(n >= 300), 32'd0);
    endtask

    function automatic int first_at(input int q[$], input int base);
        return (q.size() > 0) ? q[0] - base : -1;
    endfunction

    initial begin
        clr    = 1'b1;
        ped_ns = 1'b0;
        ped_ew = 1'b0;
        hold   = 1'b0;
        repeat (2) @(negedge clk1);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_remain", 32'(remain), 32'(GREEN_S));
        chk("rst_ack", 32'(ped_ack), 32'd0);
        chk("rst_s45", 32'(s45), 32'd0);
        @(negedge clk1);
        clr = 1'b0;
        model_reset();
        cyc = 0;

        // Free-running cycle, no requests.
        run_idle(2 * (GREEN_S + YELLOW_S));
        chk("idle_s45_a", 32'(first_at(s45_q, 0)), 32'd44);
        chk("idle_s15_a", 32'(first_at(s15_q, 0)), 32'd59);
        chk("idle_s45_b", 32'(s45_q.size() > 1 ? s45_q[1] : -1), 32'd104);
        chk("idle_s15_b", 32'(s15_q.size() > 1 ? s15_q[1] : -1), 32'd119);

        // Early EW request truncates NS green to MIN_GREEN_S.
        go_phase(0);
        s45_q.delete();
        t0 = cyc;
        run_idle(2);
        step(0, 1, 0);
        go_phase(2);
        chk("trunc_early", 32'(first_at(s45_q, t0)), 32'd9);
        step(0, 0, 0);

        // Late EW request ends NS green the next cycle.
        go_phase(0);
        s45_q.delete();
        t0 = cyc;
        run_idle(20);
        step(0, 1, 0);
        go_phase(2);
        chk("trunc_late", 32'(first_at(s45_q, t0)), 32'd21);

        // Hold mid EW green stretches it by the held cycles.
        s45_q.delete();
        t0 = cyc;
        run_idle(10);
        repeat (5) step(0, 0, 1);
        go_phase(3);
        chk("hold_green_len", 32'(first_at(s45_q, t0)), 32'd49);

        // Hold while the counter sits at zero.
        go_phase(0);
        s45_q.delete();
        t0 = cyc;
        run_idle(GREEN_S - 1);
        repeat (3) step(0, 0, 1);
        step(0, 0, 0);
        chk("hold_zero_strobe", 32'(first_at(s45_q, t0)), 32'd47);

        // NS request during NS green is ignored.
        go_phase(0);
        repeat (5) step(1, 0, 0);
        go_phase(2);
        s45_q.delete();
        t0 = cyc;
        go_phase(3);
        chk("ns_in_green_len", 32'(first_at(s45_q, t0)), 32'd44);

        // Asynchronous clear in EW yellow discards a pending NS request.
        go_phase(2);
        step(1, 0, 0);
        go_phase(3);
        run_idle(YELLOW_S - 8);
        ped_ns = 1'b0;
        ped_ew = 1'b0;
        hold   = 1'b0;
        #1;
        chk("pre_clr_remain", 32'(remain), 32'd8);
        #1;
        clr = 1'b1;
        #1;
        chk("clr_phase", 32'(phase), 32'd0);
        chk("clr_remain", 32'(remain), 32'(GREEN_S));
        chk("clr_ack", 32'(ped_ack), 32'd0);
        @(negedge clk1);
        clr = 1'b0;
        model_reset();
        go_phase(2);
        go_phase(0);
        step(0, 0, 0);

        // Random pedestrian and hold traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
